// File: rtl/regfile_pkg.sv
// Shared register-file definitions: legacy `defines plus typed package constants.
// Optional debug read port is enabled with REGFILE_DBG_PORT_EN.
`ifndef REGFILE_DEFINES_SV
`define REGFILE_DEFINES_SV
`define RegAddrBus   4:0
`define RegBus       31:0
`define RegNum       32
`define RegNumLog2   5
`define ZeroWord     32'h0000_0000
`define NOPRegAddr   5'b00000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ReadEnable   1'b1
`define ReadDisable  1'b0
`define RstEnable    1'b1
`endif

package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset, enable, $0 and same-cycle write bypass
// are resolved here ahead of the stored row.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] row,
    output logic [DATA_W-1:0] rdata
);

    // Enable is tested before any address compare so an unknown index on an
    // idle port, or an unknown write index with we=0, never reaches rdata.
    always_comb begin
        rdata = '0;
        if (!rst && re && raddr != '0) begin
            if (we && waddr == raddr)
                rdata = wdata;
            else
                rdata = row;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: one synchronous write port, two bypassed async read ports,
// $0 hardwired to zero. Define REGFILE_DBG_PORT_EN to add the dbg_addr/dbg_data port.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    logic [NUM_RD-1:0]             re_v;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] row_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

    assign re_v    = {re2, re1};
    assign raddr_v = {raddr2, raddr1};
    assign rdata1  = rdata_v[0];
    assign rdata2  = rdata_v[1];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        // No storage exists for index 0; substitute zero rather than index out of range.
        assign row_v[p] = (raddr_v[p] == '0) ? '0 : regs[raddr_v[p]];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .rst   (rst),
            .re    (re_v[p]),
            .raddr (raddr_v[p]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .row   (row_v[p]),
            .rdata (rdata_v[p])
        );
    end

`ifdef REGFILE_DBG_PORT_EN
    // Debug view is the stored state only: no bypass, no enable.
    assign dbg_data = (rst || dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed plan cases plus randomized traffic
// checked against an array-based reference model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int n_chk;
    int n_err;
    logic [31:0] model [32];

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic r_en, input logic [4:0] a);
        if (rst || !r_en || a == 5'd0) return 32'h0;
        if (we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Model-checks both read ports mid-cycle, then retires the cycle into the model.
    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, "_rd1"}, rdata1, exp_rd(re1, raddr1));
        chk({tag, "_rd2"}, rdata2, exp_rd(re2, raddr2));
`ifdef REGFILE_DBG_PORT_EN
        chk({tag, "_dbg"}, dbg_data, (rst || dbg_addr == 5'd0) ? 32'h0 : model[dbg_addr]);
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = 5'd0;
`endif
        @(posedge clk); #1;

        // Reset held two cycles with a write pending: discarded, outputs zero.
        set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 5'd5);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_rd1", rdata1, 32'h0);
            chk("rst_rd2", rdata2, 32'h0);
            step("rst");
        end
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        #1; chk("post_rst_r5", rdata1, 32'h0);
        step("post_rst");

        // Basic write then read, and disabled read.
        set_in(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
        step("wr_r3");
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        #1; chk("rd_r3", rdata1, 32'h1234_5678);
        step("rd_r3");
        re1 = 1'b0;
        #1; chk("rd_r3_dis", rdata1, 32'h0);
        step("rd_r3_dis");

        // $0 write is dropped, including the bypass path.
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        #1; chk("r0_same", rdata1, 32'h0);
        step("r0_same");
        we = 1'b0;
        #1; chk("r0_next", rdata1, 32'h0);
        step("r0_next");

        // Same-cycle bypass on both ports.
        set_in(1'b1, 5'd7, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0);
        step("wr_r7");
        set_in(1'b1, 5'd7, 32'h0000_0022, 1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        chk("byp_rd1", rdata1, 32'h0000_0022);
        chk("byp_rd2", rdata2, 32'h0000_0022);
        step("byp");
        we = 1'b0;
        #1;
        chk("byp_next_rd1", rdata1, 32'h0000_0022);
        chk("byp_next_rd2", rdata2, 32'h0000_0022);
        step("byp_next");

        // Back-to-back writes to r9 observed through bypass.
        for (int v = 1; v <= 3; v++) begin
            set_in(1'b1, 5'd9, 32'(v), 1'b0, 5'd0, 1'b1, 5'd9);
            #1; chk("b2b_byp", rdata2, 32'(v));
            step("b2b");
        end
        we = 1'b0;
        #1; chk("b2b_hold", rdata2, 32'd3);
        step("b2b_hold");

`ifdef REGFILE_DBG_PORT_EN
        // Debug port sees stored state only.
        set_in(1'b1, 5'd31, 32'hCAFE_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        dbg_addr = 5'd31;
        #1; chk("dbg_old", dbg_data, 32'h0);
        step("dbg_wr");
        we = 1'b0;
        #1; chk("dbg_new", dbg_data, 32'hCAFE_0001);
        step("dbg_rd");
`endif

        // Randomized traffic; a narrow address window makes bypass hits common.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            set_in(1'($urandom), wa, $urandom, 1'($urandom), a1, 1'($urandom), a2);
`ifdef REGFILE_DBG_PORT_EN
            dbg_addr = 5'($urandom);
`endif
            step("rnd");
        end

        // Reset mid-operation, then every register must read zero.
        rst = 1'b1;
        set_in(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b1, 5'd4, 1'b1, 5'd9);
        step("mid_rst");
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b1, 5'(31 - r));
            #1;
            chk("clr_rd1", rdata1, 32'h0);
            chk("clr_rd2", rdata2, 32'h0);
            step("clr");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit general-purpose register file. It is the consumer of the write-back stage's wd/wreg/wdata triple and the provider of operands to the decode stage.
- One synchronous write port, two asynchronous read ports.
- Write-to-read bypass, so a value retiring in WB is visible to ID in the same cycle.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width (`RegBus width)
- ADDR_W, 5, register index width (`RegAddrBus width)
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write enable, driven from wb_wreg
- waddr  input  ADDR_W  write index, driven from wb_wd
- wdata  input  DATA_W  write data, driven from wb_wdata
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 index
- rdata1  output  DATA_W  read port 1 data
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 index
- rdata2  output  DATA_W  read port 2 data

Behaviour:
- Storage: regs[1..NUM_REGS-1]. There is no storage for index 0.
- Reset: at a posedge with rst=1, all regs clear to `ZeroWord. Any write presented in that cycle is discarded.
- Write: at a posedge with rst=0, we=1 and waddr!=0, regs[waddr] <= wdata. This is a one-cycle write latency; the value is stored from the next cycle onward.
- Write to $0 (waddr==0) is silently dropped, with no side effect.
- Read ports are combinational, zero latency, and identical. Per port, evaluated in priority order:
  1. rst=1 -> `ZeroWord
  2. raddr==0 -> `ZeroWord, even if we=1 and waddr==0
  3. re=1, we=1, waddr==raddr -> wdata (same-cycle bypass)
  4. re=1 -> regs[raddr]
  5. re=0 -> `ZeroWord
- Both ports may read the same index simultaneously; both see identical data, including bypassed data.
- The bypass uses the current-cycle write inputs only. No write history is kept.
- X on waddr/raddr while the corresponding enable is 0 must not propagate to the outputs.
- Reset mid-operation: outputs are forced to zero while rst=1. After rst deasserts, every register reads zero until written.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN
- With the macro defined, extra ports are added:
  - dbg_addr  input  ADDR_W
  - dbg_data  output  DATA_W
- dbg_data = regs[dbg_addr] (zero for index 0 and during rst). There is no bypass on this port, and no enable. It is for the testbench and on-chip debug only.
- Without the macro, the ports and the logic are absent, and the module is port-identical to the base spec.

Decomposition:
- Shared defines file holds:
  - `RegAddrBus, `RegBus, `RegNum (32), `RegNumLog2 (5)
  - `ZeroWord, `NOPRegAddr
  - `WriteEnable/`WriteDisable, `ReadEnable/`ReadDisable
  - `RstEnable
- Sub-module regfile_rd_port: the combinational priority mux above (rst, re, raddr, we, waddr, wdata, storage row -> rdata). It is instantiated twice. The debug port does not use it.

Test Plan:
- Reset: hold rst=1 for 2 cycles with we=1, waddr=5, wdata=32'hDEAD_BEEF -> rdata1/rdata2=0 throughout. After release, reading r5 returns 0.
- Basic write/read: write r3=32'h1234_5678, next cycle re1=1, raddr1=3 -> rdata1=32'h1234_5678. With re1=0 -> rdata1=0.
- $0 protection: we=1, waddr=0, wdata=32'hFFFF_FFFF, with raddr1=0, re1=1 in the same and the following cycle -> rdata1=0 in both.
- Bypass: r7 holds 32'h0000_0011. In one cycle present we=1, waddr=7, wdata=32'h0000_0022, re1=re2=1, raddr1=raddr2=7 -> both read 32'h0000_0022 in that cycle and in the next.
- Back-to-back writes: write r9=1, r9=2, r9=3 on consecutive cycles while re2 reads r9 continuously -> rdata2 shows 1, 2, 3 in the write cycles via bypass, then holds 3.
- Debug port (REGFILE_DBG_PORT_EN): write r31=32'hCAFE_0001. In the write cycle dbg_addr=31 -> dbg_data shows the old value (no bypass). Next cycle -> 32'hCAFE_0001.
